// File: rtl/stim_pulse_gen_if.sv
// stim_pulse_gen_if -- control, configuration and pulse outputs of the
// stimulus pulse generator, bundled so the generator and its driver share one
// port.
//
// Parameters: CW (timing field width), BW (burst-count width).
// Signals:
//   enable, start, stop               run permission, start level, abort
//   tp1_width, td4_delay, td4_width   pulse timing, in cycles
//   period, n_bursts                  burst repetition and burst count
//   tp1, td4                          stimulus pulses
//   busy, done, burst_cnt             status
// Modports: master drives control/configuration and receives status;
// slave is the generator side.
interface stim_pulse_gen_if #(
  parameter int CW = 32,
  parameter int BW = 8
);
  logic          enable;
  logic          start;
  logic          stop;
  logic [CW-1:0] tp1_width;
  logic [CW-1:0] td4_delay;
  logic [CW-1:0] td4_width;
  logic [CW-1:0] period;
  logic [BW-1:0] n_bursts;
  logic          tp1;
  logic          td4;
  logic          busy;
  logic          done;
  logic [BW-1:0] burst_cnt;

  modport master (
    output enable, start, stop, tp1_width, td4_delay, td4_width, period, n_bursts,
    input  tp1, td4, busy, done, burst_cnt
  );

  modport slave (
    input  enable, start, stop, tp1_width, td4_delay, td4_width, period, n_bursts,
    output tp1, td4, busy, done, burst_cnt
  );
endinterface

// File: rtl/stim_pulse_gen.sv
// stim_pulse_gen -- programmable burst generator for the tp1/td4 stimulus
// pulses of the neuron top.
//
// A start (with enable) in IDLE latches the timing fields and emits n_bursts
// bursts of length max(period,1). Within a burst at counter value c:
//   tp1 = c < tp1_width
//   td4 = td4_delay <= c < td4_delay + td4_width
// Pulses are truncated at the burst end. enable low freezes the run, stop
// aborts to IDLE. A one-cycle done pulse marks completion.
//
// Ports:
//   clk_0_1ps  clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        stim_pulse_gen_if.slave (control, configuration, outputs)
//
// Optional feature: define STIM_CONT_EN to make n_bursts=0 run continuously
// (burst_cnt wraps, done never asserts). Without it, n_bursts=0 goes straight
// to DONE and pulses done once with no stimulus.
module stim_pulse_gen #(
  parameter int CW = 32,
  parameter int BW = 8
) (
  input logic             clk_0_1ps,
  input logic             reset_n,
  stim_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          tp1_q, tp1_nxt;
  logic          td4_q, td4_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          load_cfg;
  logic          zero_direct;

  // Latched run configuration
  logic [CW-1:0] w1_q;
  logic [CW-1:0] dly_q;
  logic [CW-1:0] w4_q;
  logic [CW-1:0] per_q;
  logic [BW-1:0] nb_q;

  // Low after reset until the first clock edge, so a start level held across
  // reset release is not acted on at that edge.
  logic          armed;

  function automatic logic [CW-1:0] clamp_period(input logic [CW-1:0] p);
    return (p == '0) ? CW'(1) : p;
  endfunction

  function automatic logic tp1_at(input logic [CW-1:0] c, input logic [CW-1:0] w);
    return (c < w);
  endfunction

  // End of the td4 window in CW+1 bits so delay+width never wraps.
  function automatic logic td4_at(input logic [CW-1:0] c,
                                  input logic [CW-1:0] d,
                                  input logic [CW-1:0] w);
    logic [CW:0] win_end;
    win_end = {1'b0, d} + {1'b0, w};
    return (c >= d) && ({1'b0, c} < win_end);
  endfunction

  always_ff @(posedge clk_0_1ps or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bcnt_nxt    = bcnt;
    tp1_nxt     = tp1_q;
    td4_nxt     = td4_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    load_cfg    = 1'b0;
    zero_direct = 1'b0;

    case (state)
      IDLE: begin
        tp1_nxt  = 1'b0;
        td4_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (armed && bus.start && bus.enable) begin
          load_cfg = 1'b1;
          cnt_nxt  = '0;
          bcnt_nxt = '0;
`ifdef STIM_CONT_EN
          zero_direct = 1'b0;
`else
          zero_direct = (bus.n_bursts == '0);
`endif
          if (zero_direct) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            // Outputs for counter value 0 come from the raw inputs, since the
            // latched copy only becomes valid at this same edge.
            state_nxt = RUN;
            busy_nxt  = 1'b1;
            tp1_nxt   = tp1_at('0, bus.tp1_width);
            td4_nxt   = td4_at('0, bus.td4_delay, bus.td4_width);
          end
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          tp1_nxt   = 1'b0;
          td4_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end else if (bus.enable) begin
          if (cnt == per_q - CW'(1)) begin
            cnt_nxt  = '0;
            bcnt_nxt = bcnt + BW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
          // nb_q is nonzero here unless continuous mode is running, which
          // must never terminate on a burst_cnt wrap back to zero.
          if ((cnt == per_q - CW'(1)) && (nb_q != '0) && (bcnt_nxt == nb_q)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            tp1_nxt   = 1'b0;
            td4_nxt   = 1'b0;
            busy_nxt  = 1'b0;
          end else begin
            tp1_nxt = tp1_at(cnt_nxt, w1_q);
            td4_nxt = td4_at(cnt_nxt, dly_q, w4_q);
          end
        end
      end

      DONE: begin
        // Stop and normal completion both land in IDLE with done low.
        state_nxt = IDLE;
        tp1_nxt   = 1'b0;
        td4_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        tp1_nxt   = 1'b0;
        td4_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_0_1ps or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      bcnt   <= '0;
      tp1_q  <= 1'b0;
      td4_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      armed  <= 1'b0;
      w1_q   <= '0;
      dly_q  <= '0;
      w4_q   <= '0;
      per_q  <= CW'(1);
      nb_q   <= '0;
    end else begin
      cnt    <= cnt_nxt;
      bcnt   <= bcnt_nxt;
      tp1_q  <= tp1_nxt;
      td4_q  <= td4_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      armed  <= 1'b1;
      if (load_cfg) begin
        w1_q  <= bus.tp1_width;
        dly_q <= bus.td4_delay;
        w4_q  <= bus.td4_width;
        per_q <= clamp_period(bus.period);
        nb_q  <= bus.n_bursts;
      end
    end
  end

  assign bus.tp1       = tp1_q;
  assign bus.td4       = td4_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.burst_cnt = bcnt;

endmodule

// File: tb/tb_stim_pulse_gen.sv
// tb_stim_pulse_gen -- self-checking bench for stim_pulse_gen.
// A reference model tracks the total number of active cycles k since start;
// the burst counter is k/P and the in-burst position k%P. Each clock the
// expected output word is queued before the edge and compared after it.
`timescale 1ns/1ps
module tb_stim_pulse_gen;
  localparam int CW = 32;
  localparam int BW = 8;

  logic clk_0_1ps = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_0_1ps = ~clk_0_1ps;

  stim_pulse_gen_if #(.CW(CW), .BW(BW)) bus();

  stim_pulse_gen #(.CW(CW), .BW(BW)) dut (
    .clk_0_1ps (clk_0_1ps),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: 0 idle, 1 run, 2 done
  int     m_state = 0;
  longint m_k     = 0;
  bit     m_armed = 0;
  longint m_w1 = 0, m_d = 0, m_w4 = 0, m_P = 1, m_nb = 0;

  logic [11:0] exp_q[$];

  // Observation counters
  longint cyc_no = 0;
  int     rises, dones, td4_hi, busy_hi;
  longint last_rise, gap;
  bit     prev_tp1, wrapped;
  logic [7:0] prev_bc;

  function automatic logic [11:0] model_out();
    logic   t1, t4, b, d;
    longint c;
    logic [7:0] bc;
    t1 = 0; t4 = 0; b = 0; d = 0;
    c  = m_k % m_P;
    bc = 8'((m_k / m_P) % 256);
    if (m_state == 1) begin
      b  = 1;
      t1 = (c < m_w1);
      t4 = (c >= m_d) && (c < m_d + m_w4);
    end else if (m_state == 2) begin
      d = 1;
    end
    return {t1, t4, b, d, bc};
  endfunction

  task automatic model_step();
    case (m_state)
      0: if (m_armed && bus.start && bus.enable) begin
        m_w1 = longint'(bus.tp1_width);
        m_d  = longint'(bus.td4_delay);
        m_w4 = longint'(bus.td4_width);
        m_P  = (bus.period == 0) ? 1 : longint'(bus.period);
        m_nb = longint'(bus.n_bursts);
        m_k  = 0;
`ifdef STIM_CONT_EN
        m_state = 1;
`else
        m_state = (m_nb == 0) ? 2 : 1;
`endif
      end
      1: if (bus.stop) m_state = 0;
         else if (bus.enable) begin
           m_k++;
           if (m_nb != 0 && m_k == m_nb * m_P) m_state = 2;
         end
      default: m_state = 0;
    endcase
    m_armed = 1;
  endtask

  task automatic clear_obs();
    rises = 0; dones = 0; td4_hi = 0; busy_hi = 0;
    last_rise = -1; gap = 0; wrapped = 0;
  endtask

  task automatic cyc();
    logic [11:0] e, o;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk_0_1ps);
    #1;
    cyc_no++;
    e = exp_q.pop_front();
    o = {bus.tp1, bus.td4, bus.busy, bus.done, bus.burst_cnt};
    chk("cycle_outputs", 64'(o), 64'(e));
    if (bus.tp1 && !prev_tp1) begin
      rises++;
      if (last_rise >= 0) gap = cyc_no - last_rise;
      last_rise = cyc_no;
    end
    if (bus.done) dones++;
    if (bus.td4)  td4_hi++;
    if (bus.busy) busy_hi++;
    if (prev_bc == 8'd255 && bus.burst_cnt == 8'd0) wrapped = 1;
    prev_tp1 = bus.tp1;
    prev_bc  = bus.burst_cnt;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (m_state != 0 && n < budget) begin
      cyc();
      n++;
    end
    cyc();
    chk("idle_after_run", 64'({bus.busy, bus.done}), 64'(0));
  endtask

  task automatic set_cfg(input longint w1, input longint d, input longint w4,
                         input longint p, input longint nb);
    bus.tp1_width = CW'(w1);
    bus.td4_delay = CW'(d);
    bus.td4_width = CW'(w4);
    bus.period    = CW'(p);
    bus.n_bursts  = BW'(nb);
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_armed = 0; m_P = 1;
    prev_tp1 = 0; prev_bc = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 0; bus.start = 0; bus.stop = 0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    clear_obs();

    // Power-on reset state
    #12;
    chk("reset_outputs", 64'({bus.tp1, bus.td4, bus.busy, bus.done, bus.burst_cnt}), 64'(0));

    // Start held across reset release is ignored at the release edge
    set_cfg(100, 10, 100, 10000, 6);
    bus.start = 1; bus.enable = 1;
    @(posedge clk_0_1ps); #1;
    reset_n = 1;
    cyc();
    chk("start_ignored_at_release", 64'(bus.busy), 64'(0));

    // Six bursts, period 10000
    cyc();
    bus.start = 0;
    for (int i = 0; i < 500; i++) cyc();
    set_cfg(5, 1, 5, 30, 2);   // ignored by the running burst train
    bus.start = 1;
    cyc();
    bus.start = 0;
    run_until_idle(70000);
    cyc();
    chk("s1_rises", 64'(rises), 64'(6));
    chk("s1_gap", 64'(gap), 64'(10000));
    chk("s1_done_once", 64'(dones), 64'(1));
    chk("s1_td4_cycles", 64'(td4_hi), 64'(600));
    chk("s1_burst_cnt_hold", 64'(bus.burst_cnt), 64'(6));

    // td4 window crosses the burst end and is truncated; zero tp1 width
    clear_obs();
    set_cfg(0, 40, 30, 50, 3);
    bus.start = 1; cyc(); bus.start = 0;
    run_until_idle(1000);
    chk("s2_td4_cycles", 64'(td4_hi), 64'(30));
    chk("s2_no_tp1", 64'(rises), 64'(0));

    // enable low for 25 cycles mid-pulse stretches the run
    clear_obs();
    set_cfg(20, 5, 20, 50, 2);
    bus.start = 1; cyc(); bus.start = 0;
    for (int i = 0; i < 10; i++) cyc();
    bus.enable = 0;
    for (int i = 0; i < 25; i++) cyc();
    chk("s3_hold_levels", 64'({bus.tp1, bus.td4}), 64'(2'b11));
    bus.enable = 1;
    run_until_idle(1000);
    chk("s3_busy_cycles", 64'(busy_hi), 64'(125));

    // stop at burst 3 cycle 5, then restart from burst 0
    clear_obs();
    set_cfg(10, 2, 10, 20, 6);
    bus.start = 1; cyc(); bus.start = 0;
    for (int i = 0; i < 200 && m_k != 65; i++) cyc();
    chk("s4_at_b3c5", 64'(bus.burst_cnt), 64'(3));
    bus.stop = 1; cyc(); bus.stop = 0;
    chk("s4_stop_outputs", 64'({bus.tp1, bus.td4, bus.busy, bus.done}), 64'(0));
    clear_obs();
    bus.start = 1; cyc(); bus.start = 0;
    chk("s4_restart", 64'({bus.tp1, bus.busy, bus.burst_cnt}), 64'({2'b11, 8'd0}));
    run_until_idle(1000);
    chk("s4_done_once", 64'(dones), 64'(1));

    // stop while in DONE
    set_cfg(1, 0, 1, 3, 1);
    bus.start = 1; cyc(); bus.start = 0;
    for (int i = 0; i < 20 && m_state != 2; i++) cyc();
    bus.stop = 1; cyc(); bus.stop = 0;
    chk("s4_stop_in_done", 64'({bus.busy, bus.done}), 64'(0));

    // asynchronous reset in the middle of a td4 pulse
    clear_obs();
    set_cfg(10, 5, 30, 50, 2);
    bus.start = 1; cyc(); bus.start = 0;
    for (int i = 0; i < 15; i++) cyc();
    #2;
    reset_n = 0;
    #1;
    chk("s5_async_clear", 64'({bus.tp1, bus.td4, bus.busy, bus.done, bus.burst_cnt}), 64'(0));
    model_reset();
    @(posedge clk_0_1ps); #1;
    chk("s5_held_in_reset", 64'({bus.tp1, bus.td4, bus.busy, bus.burst_cnt}), 64'(0));
    reset_n = 1;
    bus.start = 1;
    cyc();
    cyc();
    bus.start = 0;
    clear_obs();
    run_until_idle(1000);
    chk("s5_rises", 64'(rises), 64'(1));
    chk("s5_done_once", 64'(dones), 64'(1));
    chk("s5_burst_cnt", 64'(bus.burst_cnt), 64'(2));

    // n_bursts = 0
    clear_obs();
    set_cfg(1, 0, 1, 2, 0);
    bus.start = 1; cyc(); bus.start = 0;
`ifdef STIM_CONT_EN
    for (int i = 0; i < 620; i++) cyc();
    chk("s6_wrapped", 64'(wrapped), 64'(1));
    chk("s6_many_bursts", 64'(rises > 300), 64'(1));
    bus.stop = 1; cyc(); bus.stop = 0;
    chk("s6_no_done", 64'(dones), 64'(0));
    chk("s6_stopped", 64'(bus.busy), 64'(0));
`else
    chk("s6_done_pulse", 64'({bus.done, bus.tp1, bus.busy}), 64'(3'b100));
    cyc();
    cyc();
    chk("s6_done_once", 64'(dones), 64'(1));
    chk("s6_no_tp1", 64'(rises), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
